// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - single-port RAM access controller with optional zero-fill
// Accepts one request at a time, issues it to the RAM and returns read data with backpressure.
module ram_access_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int INIT_EN = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, RD_WAIT, RSP} state_t;

  localparam state_t     RST_STATE = (INIT_EN != 0) ? INIT : IDLE;
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   init_cnt, init_cnt_nxt;
  logic [1:0]        wait_cnt, wait_cnt_nxt;
  logic              cap_we, cap_we_nxt;
  logic              rsp_valid_nxt, init_done_nxt, ram_en_nxt, ram_we_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt, rsp_data_nxt;

  // init_done gates IDLE so nothing is accepted on the first edge after reset when INIT is skipped
  assign req_ready = (state == IDLE) && init_done;

  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    wait_cnt_nxt  = wait_cnt;
    cap_we_nxt    = cap_we;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    init_done_nxt = init_done;
    ram_en_nxt    = 1'b0;
    ram_we_nxt    = 1'b0;
    ram_addr_nxt  = ram_addr;
    w_data_nxt    = '0;
    case (state)
      INIT: begin
        // the extra counter bit marks that the top address has been written
        if (init_cnt[ADDR_W]) begin
          state_nxt     = IDLE;
          init_done_nxt = 1'b1;
        end else begin
          ram_en_nxt   = 1'b1;
          ram_we_nxt   = 1'b1;
          ram_addr_nxt = init_cnt[ADDR_W-1:0];
          init_cnt_nxt = init_cnt + 1'b1;
        end
      end
      IDLE: begin
        init_done_nxt = 1'b1;
        if (req_valid && req_ready) begin
          ram_en_nxt   = 1'b1;
          ram_we_nxt   = req_we;
          ram_addr_nxt = req_addr;
          w_data_nxt   = req_we ? req_wdata : '0;
          cap_we_nxt   = req_we;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt    = cap_we ? IDLE : RD_WAIT;
        wait_cnt_nxt = WAIT_LOAD;
      end
      RD_WAIT: begin
        if (wait_cnt == 2'd0) begin
          rsp_data_nxt  = r_data;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end else begin
          wait_cnt_nxt = wait_cnt - 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= RST_STATE;
      init_cnt  <= '0;
      wait_cnt  <= '0;
      cap_we    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      init_done <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      w_data    <= '0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      cap_we    <= cap_we_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      init_done <= init_done_nxt;
      ram_en    <= ram_en_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      w_data    <= w_data_nxt;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed scoreboard bench for ram_access_ctrl
module tb_ram_access_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       ram_preset = 1'b1;

  logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, init_done, ram_en, ram_we;
  logic [7:0] rsp_data, w_data, r1_data;
  logic [3:0] ram_addr;

  logic       d3_req_valid = 1'b0, d3_req_we = 1'b0, d3_rsp_ready = 1'b1;
  logic [3:0] d3_req_addr = '0;
  logic [7:0] d3_req_wdata = '0;
  logic       d3_req_ready, d3_rsp_valid, d3_init_done, d3_ram_en, d3_ram_we;
  logic [7:0] d3_rsp_data, d3_w_data, r3_data, p0, p1;
  logic [3:0] d3_ram_addr;

  logic [7:0] ram1 [16];
  logic [7:0] ram3 [16];
  logic [7:0] ref_mem [16];
  logic [7:0] exp_q [$];
  int         checks = 0, failures = 0, rsp_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  ram_access_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .INIT_EN(1)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .w_data(w_data), .r_data(r1_data)
  );

  ram_access_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .INIT_EN(1)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_we(d3_req_we),
    .req_addr(d3_req_addr), .req_wdata(d3_req_wdata),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_data(d3_rsp_data),
    .init_done(d3_init_done), .ram_en(d3_ram_en), .ram_we(d3_ram_we),
    .ram_addr(d3_ram_addr), .w_data(d3_w_data), .r_data(r3_data)
  );

  // external RAMs: one-cycle and three-cycle read latency, preset to a non-zero pattern
  always @(posedge sys_clk) begin
    if (ram_preset) begin
      for (int i = 0; i < 16; i++) ram1[i] <= 8'hEE;
    end else if (ram_en && ram_we) begin
      ram1[ram_addr] <= w_data;
    end
    if (ram_en && !ram_we) r1_data <= ram1[ram_addr];
  end

  always @(posedge sys_clk) begin
    if (ram_preset) begin
      for (int i = 0; i < 16; i++) ram3[i] <= 8'hEE;
    end else if (d3_ram_en && d3_ram_we) begin
      ram3[d3_ram_addr] <= d3_w_data;
    end
    if (d3_ram_en && !d3_ram_we) p0 <= ram3[d3_ram_addr];
    p1      <= p0;
    r3_data <= p1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one clock: score handshakes just before the edge, return 1 time unit after it
  task automatic tick;
    @(negedge sys_clk);
    if (req_valid && req_ready) begin
      if (req_we) ref_mem[req_addr] = req_wdata;
      else        exp_q.push_back(ref_mem[req_addr]);
    end
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++;
      chk("rsp_has_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_ram_en"},    32'(ram_en),    32'd0);
    chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
    chk({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    chk({tag, "_w_data"},    32'(w_data),    32'd0);
  endtask

  task automatic check_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick;
      chk({tag, "_en"},   32'(ram_en && ram_we), 32'd1);
      chk({tag, "_addr"}, 32'(ram_addr), 32'(i));
      chk({tag, "_data"}, 32'(w_data), 32'd0);
      chk({tag, "_done_early"}, 32'(init_done), 32'd0);
      chk({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
    end
    tick;
    chk({tag, "_done"},      32'(init_done), 32'd1);
    chk({tag, "_ready"},     32'(req_ready), 32'd1);
    chk({tag, "_en_off"},    32'(ram_en), 32'd0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick;
      n++;
    end
  endtask

  initial begin
    int n, idx, guard, base;
    logic acc;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

    tick;
    tick;
    check_reset_vals("rst");
    ram_preset = 1'b0;
    sys_rst    = 1'b1;
    check_init("init");

    // write 0xA5 to 3; inputs change after accept and must be ignored
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
    tick;
    req_valid = 1'b0; req_addr = 4'd8; req_wdata = 8'h11;
    chk("wr_issue_en",    32'(ram_en && ram_we), 32'd1);
    chk("wr_issue_addr",  32'(ram_addr), 32'd3);
    chk("wr_issue_data",  32'(w_data), 32'hA5);
    chk("wr_issue_ready", 32'(req_ready), 32'd0);
    tick;
    chk("wr_done_en",    32'(ram_en), 32'd0);
    chk("wr_done_wdata", 32'(w_data), 32'd0);
    chk("wr_done_ready", 32'(req_ready), 32'd1);

    // read back 3 with RD_LAT=1
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    tick;
    req_valid = 1'b0;
    chk("rd_issue_en",    32'(ram_en), 32'd1);
    chk("rd_issue_we",    32'(ram_we), 32'd0);
    chk("rd_issue_wdata", 32'(w_data), 32'd0);
    wait_rsp(n);
    chk("rd_latency", 32'(n), 32'd2);
    chk("rd_data_a5", 32'(rsp_data), 32'hA5);
    tick;
    chk("rd_valid_drop", 32'(rsp_valid), 32'd0);
    chk("rd_idle_ready", 32'(req_ready), 32'd1);

    // backpressure: response held for 5 cycles, concurrent requests ignored
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'h3C;
    tick;
    req_valid = 1'b0;
    tick;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    tick;
    req_valid = 1'b0;
    wait_rsp(n);
    chk("bp_latency", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_wdata = 8'hFF;
      tick;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data",  32'(rsp_data), 32'h3C);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_ready", 32'(req_ready), 32'd1);

    // alternating write/read stream with req_valid held high
    base = rsp_cnt; idx = 0; guard = 0;
    while (idx < 16 && guard < 200) begin
      req_valid = 1'b1;
      req_we    = (idx % 2 == 0);
      req_addr  = 4'((idx / 2) * 5 + 2);
      req_wdata = req_we ? 8'((idx / 2) * 29 + 7) : 8'h55;
      acc = req_ready;
      tick;
      if (acc) idx++;
      guard++;
    end
    req_valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      tick;
      guard++;
    end
    tick;
    tick;
    chk("stream_accepts", 32'(idx), 32'd16);
    chk("stream_rsp_cnt", 32'(rsp_cnt - base), 32'd8);
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // reset during RD_WAIT
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    tick;
    req_valid = 1'b0;
    tick;
    sys_rst = 1'b0;
    #1;
    check_reset_vals("rst_rdwait");
    exp_q.delete();
    tick;
    tick;
    sys_rst = 1'b1;

    // reset during INIT at address 7
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("reinit_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("reinit_addr7", 32'(ram_addr), 32'd7);
    sys_rst = 1'b0;
    #1;
    check_reset_vals("rst_init");
    tick;
    sys_rst = 1'b1;
    check_init("reinit");
    chk("reinit_q_empty", 32'(exp_q.size()), 32'd0);

    // RD_LAT=3 read of address 15 after INIT
    chk("d3_init_done", 32'(d3_init_done), 32'd1);
    d3_req_valid = 1'b1; d3_req_we = 1'b0; d3_req_addr = 4'd15;
    tick;
    d3_req_valid = 1'b0;
    n = 0;
    while (!d3_rsp_valid && n < 20) begin
      tick;
      n++;
    end
    chk("d3_latency", 32'(n), 32'd4);
    chk("d3_data",    32'(d3_rsp_data), 32'h00);
    tick;
    chk("d3_valid_drop", 32'(d3_rsp_valid), 32'd0);
    chk("d3_ready",      32'(d3_req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
